uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter that serialises DATA_W-bit words into start / data / optional parity / stop frames on a single line. Bit timing is derived from an external single-cycle baud tick, with OVERSAMPLE ticks per bit. Words are accepted through a valid/ready handshake, so a FIFO or host bus can feed it directly. It is the transmit half of the UART link and drives the serial line to the receiver.

## Interface
- DATA_W, 8: data bits per frame; legal 5..9.
- OVERSAMPLE, 16: baud ticks per bit period; legal 1..256.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud_tick  in  1  one-cycle enable from the baud generator; counted only when high.
- tx_valid  in  1  word available on tx_data.
- tx_ready  out  1  block can accept a word.
- tx_data  in  DATA_W  word to send, LSB first.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 mark (always 1).
- two_stop  in  1  0 = one stop bit, 1 = two stop bits.
- txd  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse when the final stop bit completes.

## Operation
- Reset values: txd=1, tx_ready=1, busy=0, tx_done=0, state IDLE, all counters 0.
- States and transitions:
  - IDLE: on accept (tx_valid & tx_ready), go to START.
  - START to DATA.
  - DATA to PARITY if parity_mode≠0, otherwise to STOP.
  - PARITY to STOP.
  - STOP to IDLE.
- Accept:
  - Latch tx_data, parity_mode and two_stop into shadow registers.
  - Clear the tick counter and the bit index.
  - Changes on the inputs mid-frame have no effect.
- Bit period:
  - The tick counter increments on baud_tick.
  - When it reaches OVERSAMPLE-1 with baud_tick high, the bit ends: the counter wraps to 0 and the FSM advances or the bit index increments.
- txd by state:
  - START: 0.
  - DATA: shadow[bit_idx], bit_idx from 0 to DATA_W-1.
  - PARITY: ^data (even), ~^data (odd), 1 (mark).
  - STOP: 1, for 1 or 2 bit periods.
- Handshake:
  - tx_ready = (state==IDLE).
  - busy = ~tx_ready.
  - tx_valid may stay high; it is not consumed outside IDLE.
- tx_done pulses in the same cycle that STOP exits to IDLE.
  - tx_ready is high in that cycle only if the FSM has registered IDLE. It is high in the following cycle.
  - A pending tx_valid is accepted in that following cycle.
- Reset asserted mid-frame: txd forces 1 immediately (asynchronously), the frame is discarded and no tx_done is issued.

## Timing
- Latency from accept edge to txd=0: 1 clk. txd is registered and has no combinational path from inputs.
- Frame length = OVERSAMPLE × (1 + DATA_W + P + S) baud ticks, where P = (parity_mode≠0) and S = 1 + two_stop.
- Back-to-back frames have a gap of exactly 1 clk of idle-high between the last stop bit and the next start bit (the IDLE/accept cycle). Sub-tick, not a bit period.
- baud_tick high on every clk: each bit lasts exactly OVERSAMPLE clk cycles.
- baud_tick arriving in the accept cycle is ignored. Counting starts the cycle after accept.
- OVERSAMPLE=1: every baud_tick ends a bit. The counter width is max(1, clog2(OVERSAMPLE)).

## Structure
- Shared package uart_pkg:
  - parity mode encodings PAR_NONE/PAR_EVEN/PAR_ODD/PAR_MARK;
  - tx state encoding (IDLE, START, DATA, PARITY, STOP);
  - idle line level constant.
- Sub-module uart_bit_timer: parametrised by OVERSAMPLE; takes clk, rst_n, clear and baud_tick; outputs a one-cycle bit_end. The receiver reuses it.
- FSM, shadow registers and txd mux stay in uart_tx_frame.

## Test plan
- DATA_W=8, OVERSAMPLE=4, baud_tick=1, even parity, one stop, tx_data=0xA5 → txd per 4 clk: 0,1,0,1,0,0,1,0,1,0,1. Parity 0; total 44 clk; tx_done one pulse.
- Same stimulus, odd parity, two_stop=1 → parity bit 1, stop high for 8 clk, frame 48 clk.
- DATA_W=7, parity none, tx_data=0x7F, tx_valid held high for two words → start bits separated by exactly 1 idle clk; tx_ready high only in IDLE.
- baud_tick every 3rd clk, OVERSAMPLE=16 → each bit lasts 48 clk; tx_data and parity_mode changed mid-frame do not alter txd.
- rst_n pulled low in the DATA state → txd=1 and tx_ready=1 immediately, no tx_done; the next accepted word frames correctly.
- parity_mode=3 with tx_data=0x00 → parity bit 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter states, line level.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [1:0] PAR_MARK = 2'd3;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Parity bit for a frame given the reduction-XOR of its data bits.
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    logic p;
    case (mode)
      PAR_EVEN: p = data_xor;
      PAR_ODD:  p = ~data_xor;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word interface feeding the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
) ();
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Counts baud ticks and flags the tick that completes one bit period.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic baud_tick,
  output logic bit_end
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;

  // A clear cycle never ends a bit, so a tick coincident with clear is dropped.
  assign bit_end = baud_tick & ~clear & (r_cnt == CNT_LAST);

  // Tick counter: wraps to 0 on the last tick of each bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (baud_tick) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one word per frame as start/data/parity/stop.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud_tick,
  uart_tx_frame_if.slave   tx_if,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_bit_idx_next;
  logic              r_stop_idx;
  logic              w_stop_idx_next;
  logic [DATA_W-1:0] r_shadow;
  logic [1:0]        r_par_mode;
  logic              r_two_stop;
  logic              r_txd;
  logic              w_txd_next;
  logic              r_tx_done;
  logic              w_done_next;
  logic              w_ready;
  logic              w_accept;
  logic              w_timer_clear;
  logic              w_bit_end;

  assign w_ready        = (r_state == IDLE);
  assign w_accept       = tx_if.tx_valid & w_ready;
  assign tx_if.tx_ready = w_ready;
  assign busy           = ~w_ready;
  assign txd            = r_txd;
  assign tx_done        = r_tx_done;

  // Timer is held at zero while idle, so counting starts the cycle after accept.
  assign w_timer_clear = (r_state == IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_timer_clear),
    .baud_tick (baud_tick),
    .bit_end   (w_bit_end)
  );

  // Next-state logic: advance one bit position per completed bit period.
  always_comb begin
    w_state_next    = r_state;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_done_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next    = START;
          w_bit_idx_next  = '0;
          w_stop_idx_next = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == IDX_LAST) begin
            w_state_next = (r_par_mode != PAR_NONE) ? PARITY : STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && !r_stop_idx) begin
            w_stop_idx_next = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Line level for the upcoming state, registered so txd is glitch-free.
  always_comb begin
    w_txd_next = LINE_IDLE;
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = r_shadow[w_bit_idx_next];
      PARITY:  w_txd_next = parity_bit(r_par_mode, ^r_shadow);
      default: w_txd_next = LINE_IDLE;
    endcase
  end

  // State, bit position, line and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_txd      <= LINE_IDLE;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_txd      <= w_txd_next;
      r_tx_done  <= w_done_next;
    end
  end

  // Shadow copy of the word and its framing options, frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_par_mode <= PAR_NONE;
      r_two_stop <= 1'b0;
    end else if (w_accept) begin
      r_shadow   <= tx_if.tx_data;
      r_par_mode <= parity_mode;
      r_two_stop <= two_stop;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle line check against a tick-count frame model.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       txd_a, busy_a, done_a;
  logic       txd_b, busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_W(8)) if_a ();
  uart_tx_frame_if #(.DATA_W(7)) if_b ();

  uart_tx_frame #(.DATA_W(8), .OVERSAMPLE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_if(if_a),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .txd(txd_a), .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_frame #(.DATA_W(7), .OVERSAMPLE(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_if(if_b),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .txd(txd_b), .busy(busy_b), .tx_done(done_b)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic rd_txd(input int sel);
    return (sel == 0) ? txd_a : txd_b;
  endfunction
  function automatic logic rd_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic rd_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction
  function automatic logic rd_ready(input int sel);
    return (sel == 0) ? if_a.tx_ready : if_b.tx_ready;
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) if_a.tx_valid = v;
    else          if_b.tx_valid = v;
  endtask

  task automatic set_data(input int sel, input logic [8:0] d);
    if (sel == 0) if_a.tx_data = d[7:0];
    else          if_b.tx_data = d[6:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word and checks every cycle of the frame. Expected line level in
  // each cycle = frame[ticks_counted / OVERSAMPLE]; ticks in the accept cycle
  // do not count. tp: baud_tick asserted every tp-th cycle after accept.
  task automatic run_frame(input int sel, input logic [8:0] data, input logic [1:0] pm,
                           input logic ts, input int tp, input bit mutate,
                           input bit keep_valid, input int abort_at);
    int   dw, os, nbits, ones, t, len;
    logic bits[$];
    dw = (sel == 0) ? 8 : 7;
    os = (sel == 0) ? 4 : 16;
    bits = {};
    bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < dw; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pm == 2'd1) bits.push_back((ones % 2) == 1);
    if (pm == 2'd2) bits.push_back((ones % 2) == 0);
    if (pm == 2'd3) bits.push_back(1'b1);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    nbits = bits.size();

    chk("ready_before_accept", rd_ready(sel), 1'b1);
    set_data(sel, data);
    set_valid(sel, 1'b1);
    parity_mode = pm;
    two_stop    = ts;
    baud_tick   = 1'b1;
    step();
    if (!keep_valid) set_valid(sel, 1'b0);

    t   = 0;
    len = -1;
    for (int j = 0; j < os * nbits * tp + 8; j++) begin
      if (t / os < nbits) begin
        chk("txd_bit", rd_txd(sel), bits[t / os]);
        chk("busy_in_frame", rd_busy(sel), 1'b1);
        chk("ready_in_frame", rd_ready(sel), 1'b0);
        chk("done_in_frame", rd_done(sel), 1'b0);
      end else begin
        chk("txd_after_frame", rd_txd(sel), 1'b1);
        chk("done_pulse", rd_done(sel), 1'b1);
        chk("ready_after_frame", rd_ready(sel), 1'b1);
        len = j;
        break;
      end
      if (j == abort_at) return;
      if (mutate && j == os * tp * 3) begin
        set_data(sel, ~data);
        parity_mode = pm ^ 2'b11;
        two_stop    = ~ts;
      end
      baud_tick = ((j + 1) % tp) == 0;
      step();
      if (baud_tick) t++;
    end
    chk_int("frame_len_clk", len, os * nbits * tp);
    $display("frame dut=%0d data=0x%0h parity=%0d two_stop=%0b tick_every=%0d len=%0d",
             sel, data, pm, ts, tp, len);
    if (!keep_valid) begin
      baud_tick = 1'b0;
      step();
      chk("done_single_pulse", rd_done(sel), 1'b0);
      chk("txd_idle_high", rd_txd(sel), 1'b1);
    end
  endtask

  initial begin
    logic [8:0] rd;
    rst_n       = 1'b0;
    baud_tick   = 1'b0;
    parity_mode = 2'd0;
    two_stop    = 1'b0;
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    set_data(0, 9'h000);
    set_data(1, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_txd", rd_txd(s), 1'b1);
      chk("reset_ready", rd_ready(s), 1'b1);
      chk("reset_busy", rd_busy(s), 1'b0);
      chk("reset_done", rd_done(s), 1'b0);
    end
    rst_n = 1'b1;
    step();
    step();

    // 0xA5 even parity one stop: 44 clk; odd parity two stops: 48 clk
    run_frame(0, 9'h0A5, 2'd1, 1'b0, 1, 1'b0, 1'b0, -1);
    run_frame(0, 9'h0A5, 2'd2, 1'b1, 1, 1'b0, 1'b0, -1);

    // Back-to-back 7-bit frames with tx_valid held high
    run_frame(1, 9'h07F, 2'd0, 1'b0, 1, 1'b0, 1'b1, -1);
    run_frame(1, 9'h07F, 2'd0, 1'b0, 1, 1'b0, 1'b0, -1);

    // Tick every 3rd clk, inputs changed mid-frame
    run_frame(1, 9'h05A, 2'd1, 1'b0, 3, 1'b1, 1'b0, -1);

    // Reset during DATA, then a clean frame
    run_frame(0, 9'h0C3, 2'd1, 1'b0, 1, 1'b0, 1'b0, 14);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_txd", txd_a, 1'b1);
    chk("async_reset_ready", if_a.tx_ready, 1'b1);
    chk("async_reset_busy", busy_a, 1'b0);
    step();
    chk("reset_no_done", done_a, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_reset_done", done_a, 1'b0);
    chk("post_reset_txd", txd_a, 1'b1);
    $display("reset applied mid-frame on dut=0");
    run_frame(0, 9'h03C, 2'd2, 1'b0, 1, 1'b0, 1'b0, -1);

    // Mark parity with all-zero data
    run_frame(0, 9'h000, 2'd3, 1'b0, 1, 1'b0, 1'b0, -1);

    // Randomised frames on both instances
    for (int k = 0; k < 8; k++) begin
      rd = 9'($urandom);
      run_frame(int'($urandom_range(0, 1)), rd, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), int'($urandom_range(1, 2)), 1'b0, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
